// File: rtl/branch1_item_reader.sv
// Read-side sequencer: sweeps the shared sys/parity LLR RAM address space once per frame,
// absorbs the RAM read latency and hands each item pair to the branch-1 calc service.
module branch1_item_reader #(
    parameter int DWIDTH      = 16,
    parameter int BRANCH_SIZE = 3072,
    parameter int RD_LATENCY  = 1,
    localparam int AW         = (BRANCH_SIZE > 1) ? $clog2(BRANCH_SIZE) : 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     i_start,
    input  logic                     i_pause,
    output logic                     o_rd_en,
    output logic [AW-1:0]            o_raddr,
    input  logic signed [DWIDTH-1:0] i_sys_rdata,
    input  logic signed [DWIDTH-1:0] i_par_rdata,
    output logic signed [DWIDTH-1:0] o_sys_item,
    output logic signed [DWIDTH-1:0] o_parity_item,
    output logic [AW-1:0]            o_addr,
    output logic                     o_valid,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam logic [AW-1:0] LAST = AW'(BRANCH_SIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_next;
    logic [AW-1:0]         cnt;
    logic                  issue;
    logic [RD_LATENCY-1:0] vld_p;
    logic [AW-1:0]         addr_p [RD_LATENCY];

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = RUN;
                    if (!i_pause) begin
                        issue = 1'b1;
                        if (cnt == LAST) state_next = DRAIN;
                    end
                end
            end
            RUN: begin
                if (!i_pause) begin
                    issue = 1'b1;
                    if (cnt == LAST) state_next = DRAIN;
                end
            end
            // Wait until the final read has left the RAM pipeline and been presented.
            DRAIN: begin
                if (!o_rd_en && (vld_p == '0)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            cnt           <= '0;
            o_rd_en       <= 1'b0;
            o_raddr       <= '0;
            vld_p         <= '0;
            o_valid       <= 1'b0;
            o_addr        <= '0;
            o_sys_item    <= '0;
            o_parity_item <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state   <= state_next;
            o_rd_en <= issue;
            if (issue) begin
                o_raddr <= cnt;
                cnt     <= cnt + AW'(1);
            end else if (state == DONE) begin
                cnt <= '0;
            end
            // Issue stage -> RAM latency stages -> registered output stage
            vld_p[0] <= o_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
            o_valid <= vld_p[RD_LATENCY-1];
            if (vld_p[RD_LATENCY-1]) begin
                o_sys_item    <= i_sys_rdata;
                o_parity_item <= i_par_rdata;
                o_addr        <= addr_p[RD_LATENCY-1];
            end
            o_busy <= (state_next != IDLE);
            o_done <= (state_next == DONE);
        end
    end

    // Address side of the latency pipeline; qualified by vld_p so it needs no reset.
    always_ff @(posedge aclk) begin
        addr_p[0] <= o_raddr;
        for (int i = 1; i < RD_LATENCY; i++) addr_p[i] <= addr_p[i-1];
    end

endmodule

// File: tb/tb_branch1_item_reader.sv
// Scoreboard bench for branch1_item_reader: two instances (read latency 1 and 3) share
// clock, reset and pause; each has its own start strobe, RAM model and expected-item queue.
module tb_branch1_item_reader;

    localparam int N  = 8;
    localparam int DW = 16;

    typedef struct {
        int addr;
        int sys;
        int par;
    } item_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic pause = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    int   cyc = 0;

    logic                 rd_en_a, rd_en_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [2:0]           raddr_a, raddr_b, addr_a, addr_b;
    logic signed [DW-1:0] sys_rd_a, par_rd_a, sys_rd_b, par_rd_b;
    logic signed [DW-1:0] sys_a, par_a, sys_b, par_b;
    logic [2:0]           b1, b2;

    item_t q0[$], q1[$];
    int n_cmp = 0, n_err = 0;
    int vcount[2], dcount[2], first_rd[2], first_vld[2], last_vld[2], done_cyc[2];
    int vcyc[2][N];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    branch1_item_reader #(.DWIDTH(DW), .BRANCH_SIZE(N), .RD_LATENCY(1)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .i_start(start_a), .i_pause(pause),
        .o_rd_en(rd_en_a), .o_raddr(raddr_a), .i_sys_rdata(sys_rd_a), .i_par_rdata(par_rd_a),
        .o_sys_item(sys_a), .o_parity_item(par_a), .o_addr(addr_a), .o_valid(valid_a),
        .o_busy(busy_a), .o_done(done_a));

    branch1_item_reader #(.DWIDTH(DW), .BRANCH_SIZE(N), .RD_LATENCY(3)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .i_start(start_b), .i_pause(pause),
        .o_rd_en(rd_en_b), .o_raddr(raddr_b), .i_sys_rdata(sys_rd_b), .i_par_rdata(par_rd_b),
        .o_sys_item(sys_b), .o_parity_item(par_b), .o_addr(addr_b), .o_valid(valid_b),
        .o_busy(busy_b), .o_done(done_b));

    function automatic logic signed [DW-1:0] sys_of(input int a);
        return DW'(a + 1);
    endfunction

    function automatic logic signed [DW-1:0] par_of(input int a);
        return DW'(-(a + 1) * 10);
    endfunction

    // RAM models: one-cycle read for A, three-cycle read for B
    always @(posedge aclk) begin
        if (rd_en_a) begin
            sys_rd_a <= sys_of(int'(raddr_a));
            par_rd_a <= par_of(int'(raddr_a));
        end
        b1 <= raddr_b;
        b2 <= b1;
        sys_rd_b <= sys_of(int'(b2));
        par_rd_b <= par_of(int'(b2));
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic mon(input int i, input logic rd, input logic v, input int a,
                       input int s, input int p, input logic d);
        item_t e;
        if (v) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                check_eq($sformatf("unexpected_valid%0d", i), 1, 0);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check_eq($sformatf("addr%0d", i), a, e.addr);
                check_eq($sformatf("sys%0d", i), s, e.sys);
                check_eq($sformatf("par%0d", i), p, e.par);
            end
            if (first_vld[i] < 0) first_vld[i] = cyc;
            last_vld[i] = cyc;
            if (a >= 0 && a < N) vcyc[i][a] = cyc;
            vcount[i]++;
        end
        if (rd && first_rd[i] < 0) first_rd[i] = cyc;
        if (d) begin
            dcount[i]++;
            done_cyc[i] = cyc;
        end
    endtask

    always @(negedge aclk) begin
        mon(0, rd_en_a, valid_a, int'(addr_a), int'(sys_a), int'(par_a), done_a);
        mon(1, rd_en_b, valid_b, int'(addr_b), int'(sys_b), int'(par_b), done_b);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_stats();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            vcount[i] = 0; dcount[i] = 0; first_rd[i] = -1; first_vld[i] = -1;
            last_vld[i] = -1; done_cyc[i] = -1;
            for (int k = 0; k < N; k++) vcyc[i][k] = -1;
        end
    endtask

    // Load expected frame into both scoreboards, then pulse both starts for one edge
    task automatic begin_frame();
        item_t e;
        clear_stats();
        for (int k = 0; k < N; k++) begin
            e.addr = k; e.sys = k + 1; e.par = -(k + 1) * 10;
            q0.push_back(e);
            q1.push_back(e);
        end
        start_a = 1'b1; start_b = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (!busy_a && !busy_b) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("idle_timeout", int'(ok), 1);
    endtask

    task automatic end_frame(input int i, input int gap);
        int lat = (i == 0) ? 1 : 3;
        check_eq($sformatf("item_count%0d", i), vcount[i], N);
        check_eq($sformatf("done_count%0d", i), dcount[i], 1);
        check_eq($sformatf("done_after_last%0d", i), done_cyc[i] - last_vld[i], 1);
        check_eq($sformatf("queue_left%0d", i), (i == 0) ? q0.size() : q1.size(), 0);
        check_eq($sformatf("latency%0d", i), first_vld[i] - first_rd[i], lat + 1);
        check_eq($sformatf("gap_after2_%0d", i), vcyc[i][3] - vcyc[i][2], gap + 1);
        check_eq($sformatf("span%0d", i), vcyc[i][N-1] - vcyc[i][0], N - 1 + gap);
    endtask

    task automatic check_zero_a(input string tag);
        check_eq({tag, "_rd_en"}, int'(rd_en_a), 0);
        check_eq({tag, "_raddr"}, int'(raddr_a), 0);
        check_eq({tag, "_valid"}, int'(valid_a), 0);
        check_eq({tag, "_addr"}, int'(addr_a), 0);
        check_eq({tag, "_sys"}, int'(sys_a), 0);
        check_eq({tag, "_par"}, int'(par_a), 0);
        check_eq({tag, "_busy"}, int'(busy_a), 0);
        check_eq({tag, "_done"}, int'(done_a), 0);
        check_eq({tag, "_b_valid"}, int'(valid_b), 0);
        check_eq({tag, "_b_busy"}, int'(busy_b), 0);
        check_eq({tag, "_b_sys"}, int'(sys_b), 0);
    endtask

    initial begin
        bit seen;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        clear_stats();
        repeat (3) tick();
        check_zero_a("reset");
        aresetn = 1'b1;
        tick();

        // Basic frame on both latencies
        begin_frame();
        wait_idle();
        end_frame(0, 0);
        end_frame(1, 0);

        // Pause for three edges right after address 2 is issued
        begin_frame();
        repeat (2) tick();
        pause = 1'b1;
        repeat (3) tick();
        pause = 1'b0;
        wait_idle();
        end_frame(0, 3);
        end_frame(1, 3);

        // Start while busy, then start during DONE on each instance
        begin_frame();
        repeat (4) tick();
        start_a = 1'b1; start_b = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            tick();
            seen = done_a;
        end
        check_eq("done_a_seen", int'(seen), 1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            seen = done_b;
            if (!seen) tick();
        end
        check_eq("done_b_seen", int'(seen), 1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_idle();
        repeat (4) tick();
        check_eq("done_start_ignored_a", int'(busy_a), 0);
        check_eq("done_start_ignored_b", int'(busy_b), 0);
        end_frame(0, 0);
        end_frame(1, 0);

        // Reset after address 3 issued
        begin_frame();
        repeat (3) tick();
        aresetn = 1'b0;
        tick();
        check_zero_a("midreset");
        clear_stats();
        aresetn = 1'b1;
        repeat (8) tick();
        check_eq("post_reset_valids_a", vcount[0], 0);
        check_eq("post_reset_valids_b", vcount[1], 0);
        check_eq("post_reset_done", dcount[0] + dcount[1], 0);
        begin_frame();
        wait_idle();
        end_frame(0, 0);
        end_frame(1, 0);

        // Pause held from the start edge for five edges
        pause = 1'b1;
        begin_frame();
        repeat (4) tick();
        check_eq("hold_rd_en_a", int'(rd_en_a), 0);
        check_eq("hold_busy_a", int'(busy_a), 1);
        check_eq("hold_busy_b", int'(busy_b), 1);
        check_eq("hold_no_read", first_rd[0] + first_rd[1], -2);
        pause = 1'b0;
        wait_idle();
        end_frame(0, 0);
        end_frame(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
